decode_stage: RTL and testbench

DECODE_STAGE -- requirements
Module: decode_stage

---
 rtl/mips_pkg.sv | 78 +++++++
 rtl/register_file.sv | 74 +++++++
 rtl/decode_stage.sv | 165 ++++++++++++++++
 tb/tb_decode_stage.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: opcodes, ALU operation codes and the
// ID/EX control/data bundle used by Decode and Execute.
package mips_pkg;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_SLTI  = 6'h0A;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   typedef enum logic [2:0] {
      ALU_ADD   = 3'b000,
      ALU_SUB   = 3'b001,
      ALU_RTYPE = 3'b010,
      ALU_AND   = 3'b011,
      ALU_OR    = 3'b100,
      ALU_SLT   = 3'b101
   } aluop_e;

   typedef struct packed {
      aluop_e alu_op;
      logic   alu_src;
      logic   reg_write;
      logic   mem_read;
      logic   mem_write;
      logic   mem_to_reg;
      logic   branch;
      logic   valid;
      logic   illegal;
   } ctrl_t;

   localparam ctrl_t CTRL_BUBBLE = '{
      alu_op:     ALU_ADD,
      alu_src:    1'b0,
      reg_write:  1'b0,
      mem_read:   1'b0,
      mem_write:  1'b0,
      mem_to_reg: 1'b0,
      branch:     1'b0,
      valid:      1'b0,
      illegal:    1'b0
   };

   typedef struct packed {
      ctrl_t       ctrl;
      logic [4:0]  dest_reg;
      logic [31:0] input_a;
      logic [31:0] input_b;
      logic [31:0] immediate;
      logic [31:0] next_pc;
      logic [4:0]  shamt;
      logic [5:0]  funct;
   } idex_t;

   localparam idex_t IDEX_BUBBLE = '{
      ctrl:      CTRL_BUBBLE,
      dest_reg:  5'd0,
      input_a:   32'd0,
      input_b:   32'd0,
      immediate: 32'd0,
      next_pc:   32'd0,
      shamt:     5'd0,
      funct:     6'd0
   };

   // Logical immediates (andi/ori) are zero-extended, everything else sign-extended.
   function automatic logic [31:0] extend_imm(input logic [15:0] imm, input logic zero_ext);
      if (zero_ext) begin
         extend_imm = {16'h0000, imm};
      end else begin
         extend_imm = {{16{imm[15]}}, imm};
      end
   endfunction

endpackage

// File: rtl/register_file.sv
// 32 x 32 register file: two combinational read ports with write-through
// bypass, one synchronous write port, $0 hardwired to zero.
module register_file
   import mips_pkg::*;
#(
   parameter bit CLEAR_ON_RESET = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [4:0]  rd_addr_a_i,
   input  logic [4:0]  rd_addr_b_i,
   input  logic        wr_en_i,
   input  logic [4:0]  wr_addr_i,
   input  logic [31:0] wr_data_i,
   output logic [31:0] rd_data_a_o,
   output logic [31:0] rd_data_b_o
);

   logic [31:0] regs_q [0:31];
   logic        wr_valid_s;
   logic        bypass_a_s;
   logic        bypass_b_s;

   assign wr_valid_s = wr_en_i && (wr_addr_i != 5'd0);
   assign bypass_a_s = wr_valid_s && (wr_addr_i == rd_addr_a_i);
   assign bypass_b_s = wr_valid_s && (wr_addr_i == rd_addr_b_i);

   generate
      if (CLEAR_ON_RESET) begin : g_clear
         // Storage cleared by reset; reset also swallows a coincident writeback.
         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               for (int i = 0; i < 32; i++) begin
                  regs_q[i] <= 32'd0;
               end
            end else if (wr_valid_s) begin
               regs_q[wr_addr_i] <= wr_data_i;
            end
         end
      end else begin : g_keep
         // Contents survive reset; only writebacks during reset are dropped.
         always_ff @(posedge clk) begin
            if (wr_valid_s && !reset) begin
               regs_q[wr_addr_i] <= wr_data_i;
            end
         end
      end
   endgenerate

   // Read port A with $0 forcing and same-cycle bypass.
   always_comb begin
      rd_data_a_o = 32'd0;
      if (rd_addr_a_i == 5'd0) begin
         rd_data_a_o = 32'd0;
      end else if (bypass_a_s) begin
         rd_data_a_o = wr_data_i;
      end else begin
         rd_data_a_o = regs_q[rd_addr_a_i];
      end
   end

   // Read port B with $0 forcing and same-cycle bypass.
   always_comb begin
      rd_data_b_o = 32'd0;
      if (rd_addr_b_i == 5'd0) begin
         rd_data_b_o = 32'd0;
      end else if (bypass_b_s) begin
         rd_data_b_o = wr_data_i;
      end else begin
         rd_data_b_o = regs_q[rd_addr_b_i];
      end
   end

endmodule

// File: rtl/decode_stage.sv
// MIPS instruction decode stage: control decode, immediate extension, register
// read and the ID/EX pipeline register with stall/flush handling.
module decode_stage
   import mips_pkg::*;
#(
   parameter bit CLEAR_RF_ON_RESET = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] instruction,
   input  logic [31:0] pcPlus4,
   input  logic        stall,
   input  logic        flush,
   input  logic        wbRegWrite,
   input  logic [4:0]  wbWriteReg,
   input  logic [31:0] wbWriteData,
   output logic [31:0] inputA,
   output logic [31:0] inputB,
   output logic [31:0] immediate,
   output logic [31:0] nextPC,
   output logic [4:0]  shamt,
   output logic [5:0]  funct,
   output logic [2:0]  ALUop,
   output logic        ALUSrc,
   output logic [4:0]  destReg,
   output logic        regWrite,
   output logic        memRead,
   output logic        memWrite,
   output logic        memToReg,
   output logic        branch,
   output logic        valid,
   output logic        illegal
);

   logic [5:0]  opcode_s;
   logic [4:0]  rs_s;
   logic [4:0]  rt_s;
   logic [4:0]  rd_s;
   logic [31:0] rs_data_s;
   logic [31:0] rt_data_s;
   idex_t       decoded_s;
   idex_t       idex_d;
   idex_t       idex_q;

   assign opcode_s = instruction[31:26];
   assign rs_s     = instruction[25:21];
   assign rt_s     = instruction[20:16];
   assign rd_s     = instruction[15:11];

   register_file #(
      .CLEAR_ON_RESET (CLEAR_RF_ON_RESET)
   ) u_register_file (
      .clk         (clk),
      .reset       (reset),
      .rd_addr_a_i (rs_s),
      .rd_addr_b_i (rt_s),
      .wr_en_i     (wbRegWrite),
      .wr_addr_i   (wbWriteReg),
      .wr_data_i   (wbWriteData),
      .rd_data_a_o (rs_data_s),
      .rd_data_b_o (rt_data_s)
   );

   // Opcode decode; unknown opcodes collapse to a bubble flagged illegal.
   always_comb begin
      decoded_s            = IDEX_BUBBLE;
      decoded_s.ctrl.valid = 1'b1;
      decoded_s.input_a    = rs_data_s;
      decoded_s.input_b    = rt_data_s;
      decoded_s.next_pc    = pcPlus4;
      decoded_s.shamt      = instruction[10:6];
      decoded_s.funct      = instruction[5:0];
      decoded_s.immediate  = extend_imm(instruction[15:0], 1'b0);
      case (opcode_s)
         OP_RTYPE: begin
            decoded_s.ctrl.alu_op    = ALU_RTYPE;
            decoded_s.ctrl.reg_write = 1'b1;
            decoded_s.dest_reg       = rd_s;
         end
         OP_LW: begin
            decoded_s.ctrl.alu_src    = 1'b1;
            decoded_s.ctrl.mem_read   = 1'b1;
            decoded_s.ctrl.mem_to_reg = 1'b1;
            decoded_s.ctrl.reg_write  = 1'b1;
            decoded_s.dest_reg        = rt_s;
         end
         OP_SW: begin
            decoded_s.ctrl.alu_src   = 1'b1;
            decoded_s.ctrl.mem_write = 1'b1;
         end
         OP_BEQ: begin
            decoded_s.ctrl.alu_op = ALU_SUB;
            decoded_s.ctrl.branch = 1'b1;
         end
         OP_ADDI: begin
            decoded_s.ctrl.alu_src   = 1'b1;
            decoded_s.ctrl.reg_write = 1'b1;
            decoded_s.dest_reg       = rt_s;
         end
         OP_ANDI: begin
            decoded_s.ctrl.alu_op    = ALU_AND;
            decoded_s.ctrl.alu_src   = 1'b1;
            decoded_s.ctrl.reg_write = 1'b1;
            decoded_s.dest_reg       = rt_s;
            decoded_s.immediate      = extend_imm(instruction[15:0], 1'b1);
         end
         OP_ORI: begin
            decoded_s.ctrl.alu_op    = ALU_OR;
            decoded_s.ctrl.alu_src   = 1'b1;
            decoded_s.ctrl.reg_write = 1'b1;
            decoded_s.dest_reg       = rt_s;
            decoded_s.immediate      = extend_imm(instruction[15:0], 1'b1);
         end
         OP_SLTI: begin
            decoded_s.ctrl.alu_op    = ALU_SLT;
            decoded_s.ctrl.alu_src   = 1'b1;
            decoded_s.ctrl.reg_write = 1'b1;
            decoded_s.dest_reg       = rt_s;
         end
         default: begin
            decoded_s              = IDEX_BUBBLE;
            decoded_s.ctrl.illegal = 1'b1;
         end
      endcase
   end

   // ID/EX next state: flush beats stall, stall holds, otherwise advance.
   always_comb begin
      idex_d = decoded_s;
      if (flush) begin
         idex_d = IDEX_BUBBLE;
      end else if (stall) begin
         idex_d = idex_q;
      end else begin
         idex_d = decoded_s;
      end
   end

   // ID/EX pipeline register; reset forces a bubble immediately.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         idex_q <= IDEX_BUBBLE;
      end else begin
         idex_q <= idex_d;
      end
   end

   assign inputA    = idex_q.input_a;
   assign inputB    = idex_q.input_b;
   assign immediate = idex_q.immediate;
   assign nextPC    = idex_q.next_pc;
   assign shamt     = idex_q.shamt;
   assign funct     = idex_q.funct;
   assign ALUop     = idex_q.ctrl.alu_op;
   assign ALUSrc    = idex_q.ctrl.alu_src;
   assign destReg   = idex_q.dest_reg;
   assign regWrite  = idex_q.ctrl.reg_write;
   assign memRead   = idex_q.ctrl.mem_read;
   assign memWrite  = idex_q.ctrl.mem_write;
   assign memToReg  = idex_q.ctrl.mem_to_reg;
   assign branch    = idex_q.ctrl.branch;
   assign valid     = idex_q.ctrl.valid;
   assign illegal   = idex_q.ctrl.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed-vector bench for decode_stage with hand-computed expectations.
module tb_decode_stage;

   logic        clk;
   logic        reset;
   logic [31:0] instruction;
   logic [31:0] pcPlus4;
   logic        stall;
   logic        flush;
   logic        wbRegWrite;
   logic [4:0]  wbWriteReg;
   logic [31:0] wbWriteData;
   logic [31:0] inputA;
   logic [31:0] inputB;
   logic [31:0] immediate;
   logic [31:0] nextPC;
   logic [4:0]  shamt;
   logic [5:0]  funct;
   logic [2:0]  ALUop;
   logic        ALUSrc;
   logic [4:0]  destReg;
   logic        regWrite;
   logic        memRead;
   logic        memWrite;
   logic        memToReg;
   logic        branch;
   logic        valid;
   logic        illegal;

   int checks = 0;
   int errors = 0;

   // Control bundle: ALUop, ALUSrc, regWrite, memRead, memWrite, memToReg, branch, valid, illegal
   logic [10:0]  ctrl_w;
   logic [154:0] all_w;
   assign ctrl_w = {ALUop, ALUSrc, regWrite, memRead, memWrite, memToReg, branch, valid, illegal};
   assign all_w  = {inputA, inputB, immediate, nextPC, shamt, funct, destReg, ctrl_w};

   localparam logic [10:0] C_RTYPE = 11'b010_0_1_0_0_0_0_1_0;
   localparam logic [10:0] C_LW    = 11'b000_1_1_1_0_1_0_1_0;
   localparam logic [10:0] C_SW    = 11'b000_1_0_0_1_0_0_1_0;
   localparam logic [10:0] C_BEQ   = 11'b001_0_0_0_0_0_1_1_0;
   localparam logic [10:0] C_ADDI  = 11'b000_1_1_0_0_0_0_1_0;
   localparam logic [10:0] C_ANDI  = 11'b011_1_1_0_0_0_0_1_0;
   localparam logic [10:0] C_ORI   = 11'b100_1_1_0_0_0_0_1_0;
   localparam logic [10:0] C_SLTI  = 11'b101_1_1_0_0_0_0_1_0;

   decode_stage #(.CLEAR_RF_ON_RESET(1'b1)) dut (
      .clk         (clk),
      .reset       (reset),
      .instruction (instruction),
      .pcPlus4     (pcPlus4),
      .stall       (stall),
      .flush       (flush),
      .wbRegWrite  (wbRegWrite),
      .wbWriteReg  (wbWriteReg),
      .wbWriteData (wbWriteData),
      .inputA      (inputA),
      .inputB      (inputB),
      .immediate   (immediate),
      .nextPC      (nextPC),
      .shamt       (shamt),
      .funct       (funct),
      .ALUop       (ALUop),
      .ALUSrc      (ALUSrc),
      .destReg     (destReg),
      .regWrite    (regWrite),
      .memRead     (memRead),
      .memWrite    (memWrite),
      .memToReg    (memToReg),
      .branch      (branch),
      .valid       (valid),
      .illegal     (illegal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [31:0] instr, input logic [31:0] pc);
      instruction = instr;
      pcPlus4     = pc;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      step();
      step();
      checks++;
      if (all_w !== 155'd0) begin
         errors++;
         $display("FAIL reset_state got=%h exp=0", all_w);
      end
      reset = 1'b0;
   endtask

   task automatic test_addi();
      drive(32'h20010005, 32'h00000004);
      step();
      checks++;
      if (ctrl_w !== C_ADDI) begin
         errors++;
         $display("FAIL addi_ctrl got=%b exp=%b", ctrl_w, C_ADDI);
      end
      checks++;
      if ({immediate, destReg, nextPC, inputA} !== {32'd5, 5'd1, 32'h4, 32'd0}) begin
         errors++;
         $display("FAIL addi_fields imm=%h dest=%0d pc=%h a=%h", immediate, destReg, nextPC, inputA);
      end
      drive(32'h2001FFFF, 32'h00000008);
      step();
      checks++;
      if (immediate !== 32'hFFFFFFFF) begin
         errors++;
         $display("FAIL addi_signext got=%h exp=ffffffff", immediate);
      end
   endtask

   task automatic test_bypass();
      wbRegWrite  = 1'b1;
      wbWriteReg  = 5'd3;
      wbWriteData = 32'hDEADBEEF;
      drive(32'h00632020, 32'h00000010);
      step();
      wbRegWrite = 1'b0;
      checks++;
      if ({inputA, inputB, destReg, funct} !== {32'hDEADBEEF, 32'hDEADBEEF, 5'd4, 6'h20}) begin
         errors++;
         $display("FAIL bypass_add a=%h b=%h dest=%0d funct=%h", inputA, inputB, destReg, funct);
      end
      checks++;
      if ({ctrl_w, immediate} !== {C_RTYPE, 32'h00002020}) begin
         errors++;
         $display("FAIL rtype_ctrl ctrl=%b imm=%h", ctrl_w, immediate);
      end
      step();
      checks++;
      if ({inputA, inputB} !== {32'hDEADBEEF, 32'hDEADBEEF}) begin
         errors++;
         $display("FAIL stored_read a=%h b=%h exp=deadbeef", inputA, inputB);
      end
   endtask

   task automatic test_immediates();
      drive(32'h34028000, 32'h00000020);
      step();
      checks++;
      if ({immediate, ctrl_w, destReg} !== {32'h00008000, C_ORI, 5'd2}) begin
         errors++;
         $display("FAIL ori imm=%h ctrl=%b dest=%0d", immediate, ctrl_w, destReg);
      end
      drive(32'h28028000, 32'h00000024);
      step();
      checks++;
      if ({immediate, ctrl_w} !== {32'hFFFF8000, C_SLTI}) begin
         errors++;
         $display("FAIL slti imm=%h ctrl=%b", immediate, ctrl_w);
      end
      drive(32'h3002FFFF, 32'h00000028);
      step();
      checks++;
      if ({immediate, ctrl_w} !== {32'h0000FFFF, C_ANDI}) begin
         errors++;
         $display("FAIL andi imm=%h ctrl=%b", immediate, ctrl_w);
      end
      drive(32'hAC220008, 32'h0000002C);
      step();
      checks++;
      if ({immediate, ctrl_w, destReg} !== {32'h00000008, C_SW, 5'd0}) begin
         errors++;
         $display("FAIL sw imm=%h ctrl=%b dest=%0d", immediate, ctrl_w, destReg);
      end
      drive(32'h1022FFFF, 32'h00000030);
      step();
      checks++;
      if ({immediate, ctrl_w, destReg, nextPC} !== {32'hFFFFFFFF, C_BEQ, 5'd0, 32'h30}) begin
         errors++;
         $display("FAIL beq imm=%h ctrl=%b dest=%0d pc=%h", immediate, ctrl_w, destReg, nextPC);
      end
      drive(32'h00031080, 32'h00000034);
      step();
      checks++;
      if ({shamt, funct, destReg} !== {5'd2, 6'h00, 5'd2}) begin
         errors++;
         $display("FAIL sll_fields shamt=%0d funct=%h dest=%0d", shamt, funct, destReg);
      end
   endtask

   task automatic test_reg0_illegal();
      wbRegWrite  = 1'b1;
      wbWriteReg  = 5'd0;
      wbWriteData = 32'h00000007;
      drive(32'h20010005, 32'h00000040);
      step();
      wbRegWrite = 1'b0;
      checks++;
      if (inputA !== 32'd0) begin
         errors++;
         $display("FAIL reg0_bypass got=%h exp=0", inputA);
      end
      step();
      checks++;
      if (inputA !== 32'd0) begin
         errors++;
         $display("FAIL reg0_read got=%h exp=0", inputA);
      end
      drive(32'hFC221234, 32'h00000044);
      step();
      checks++;
      if (all_w !== 155'd1) begin
         errors++;
         $display("FAIL illegal_opcode got=%h exp=1 (illegal only)", all_w);
      end
   endtask

   task automatic test_stall_flush();
      drive(32'h20070055, 32'h00000100);
      step();
      checks++;
      if ({immediate, destReg, nextPC, ctrl_w} !== {32'h55, 5'd7, 32'h100, C_ADDI}) begin
         errors++;
         $display("FAIL pre_stall imm=%h dest=%0d pc=%h ctrl=%b", immediate, destReg, nextPC, ctrl_w);
      end
      stall       = 1'b1;
      wbRegWrite  = 1'b1;
      wbWriteReg  = 5'd5;
      wbWriteData = 32'h00001234;
      for (int i = 0; i < 3; i++) begin
         drive(32'h34028000 + 32'(i), 32'h00000200 + 32'(i));
         step();
         wbRegWrite = 1'b0;
         checks++;
         if ({immediate, destReg, nextPC, ctrl_w} !== {32'h55, 5'd7, 32'h100, C_ADDI}) begin
            errors++;
            $display("FAIL stall_hold cyc=%0d imm=%h dest=%0d pc=%h ctrl=%b", i, immediate, destReg, nextPC, ctrl_w);
         end
      end
      stall = 1'b0;
      drive(32'h00A00000, 32'h00000300);
      step();
      checks++;
      if ({inputA, nextPC} !== {32'h00001234, 32'h300}) begin
         errors++;
         $display("FAIL wb_during_stall a=%h pc=%h exp a=1234 pc=300", inputA, nextPC);
      end
      stall = 1'b1;
      flush = 1'b1;
      step();
      checks++;
      if (all_w !== 155'd0) begin
         errors++;
         $display("FAIL flush_over_stall got=%h exp=0", all_w);
      end
      stall = 1'b0;
      flush = 1'b0;
   endtask

   task automatic test_async_reset();
      wbRegWrite  = 1'b1;
      wbWriteReg  = 5'd1;
      wbWriteData = 32'h00000011;
      step();
      wbRegWrite = 1'b0;
      drive(32'h8C220004, 32'h00000400);
      step();
      checks++;
      if ({inputA, immediate, destReg, ctrl_w} !== {32'h11, 32'h4, 5'd2, C_LW}) begin
         errors++;
         $display("FAIL lw a=%h imm=%h dest=%0d ctrl=%b", inputA, immediate, destReg, ctrl_w);
      end
      #2;
      reset       = 1'b1;
      wbRegWrite  = 1'b1;
      wbWriteReg  = 5'd6;
      wbWriteData = 32'h00000066;
      #1;
      checks++;
      if (all_w !== 155'd0) begin
         errors++;
         $display("FAIL async_reset_midcycle got=%h exp=0", all_w);
      end
      step();
      reset      = 1'b0;
      wbRegWrite = 1'b0;
      drive(32'h00260000, 32'h00000500);
      step();
      checks++;
      if ({inputA, inputB, ctrl_w, nextPC} !== {32'd0, 32'd0, C_RTYPE, 32'h500}) begin
         errors++;
         $display("FAIL post_reset_rf a=%h b=%h ctrl=%b pc=%h", inputA, inputB, ctrl_w, nextPC);
      end
   endtask

   initial begin
      reset       = 1'b1;
      instruction = 32'd0;
      pcPlus4     = 32'd0;
      stall       = 1'b0;
      flush       = 1'b0;
      wbRegWrite  = 1'b0;
      wbWriteReg  = 5'd0;
      wbWriteData = 32'd0;
      test_reset();
      test_addi();
      test_bypass();
      test_immediates();
      test_reg0_illegal();
      test_stall_flush();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
